// File: rtl/cb_multi_if.sv
// Handshake and status bundle for the multi-lane circular buffer cb_multi.
// The slave side is the buffer; the master side is the producer/consumer pair.
interface cb_multi_if #(
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned NUM_ENTRIES = 8,
   parameter int unsigned NUM_ENQ     = 2,
   parameter int unsigned NUM_DEQ     = 2
);
   localparam int unsigned LOG_NUM_ENTRIES = $clog2(NUM_ENTRIES);

   logic                                flush;
   logic [NUM_ENQ-1:0]                  enq_valid_by_lane;
   logic [NUM_ENQ-1:0][DATA_WIDTH-1:0]  enq_data_by_lane;
   logic [NUM_ENQ-1:0]                  enq_ready_by_lane;
   logic [NUM_DEQ-1:0]                  deq_valid_by_lane;
   logic [NUM_DEQ-1:0][DATA_WIDTH-1:0]  deq_data_by_lane;
   logic [NUM_DEQ-1:0]                  deq_ready_by_lane;
   logic [LOG_NUM_ENTRIES:0]            occupancy;
   logic                                full;
   logic                                empty;

   modport slave (
      input  flush,
      input  enq_valid_by_lane,
      input  enq_data_by_lane,
      output enq_ready_by_lane,
      output deq_valid_by_lane,
      output deq_data_by_lane,
      input  deq_ready_by_lane,
      output occupancy,
      output full,
      output empty
   );

   modport master (
      output flush,
      output enq_valid_by_lane,
      output enq_data_by_lane,
      input  enq_ready_by_lane,
      input  deq_valid_by_lane,
      input  deq_data_by_lane,
      output deq_ready_by_lane,
      input  occupancy,
      input  full,
      input  empty
   );
endinterface

// File: rtl/cb_multi.sv
// Multi-lane circular buffer: up to NUM_ENQ in-order writes and NUM_DEQ in-order reads per cycle.
// Optional macro CB_MULTI_PARTIAL_ENQ_EN lets a partial enqueue group in when fewer than NUM_ENQ slots are free.
module cb_multi #(
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned NUM_ENTRIES = 8,
   parameter int unsigned NUM_ENQ     = 2,
   parameter int unsigned NUM_DEQ     = 2
) (
   input  logic       CLK,
   input  logic       nRST,
   cb_multi_if.slave  bus
);
   localparam int unsigned LOG_NUM_ENTRIES = $clog2(NUM_ENTRIES);
   localparam int unsigned PTR_W           = LOG_NUM_ENTRIES + 1;

   // Pointers carry one extra wrap bit so full and empty stay distinguishable.
   logic [PTR_W-1:0]                         enq_ptr_q, enq_ptr_d;
   logic [PTR_W-1:0]                         deq_ptr_q, deq_ptr_d;
   logic [DATA_WIDTH-1:0]                    entries_q [NUM_ENTRIES];

   logic [PTR_W-1:0]                         occupancy_c;
   logic [PTR_W-1:0]                         free_c;
   logic [PTR_W-1:0]                         enq_cnt_c;
   logic [PTR_W-1:0]                         deq_cnt_c;
   logic [NUM_ENQ-1:0]                       enq_ready_c;
   logic [NUM_ENQ-1:0]                       enq_take_c;
   logic                                     enq_run_c;
   logic [NUM_DEQ-1:0]                       deq_valid_c;
   logic                                     deq_run_c;
   logic [NUM_ENQ-1:0][LOG_NUM_ENTRIES-1:0]  enq_idx_c;
   logic [NUM_DEQ-1:0][LOG_NUM_ENTRIES-1:0]  deq_idx_c;

   always_comb begin
      occupancy_c = enq_ptr_q - deq_ptr_q;
      free_c      = PTR_W'(NUM_ENTRIES) - occupancy_c;
   end

   // Enqueue acceptance looks only at registered state, never at this cycle's dequeues.
   always_comb begin
      enq_ready_c = '0;
`ifdef CB_MULTI_PARTIAL_ENQ_EN
      for (int unsigned i = 0; i < NUM_ENQ; i++) begin
         enq_ready_c[i] = (free_c > PTR_W'(i));
      end
`else
      enq_ready_c = {NUM_ENQ{free_c >= PTR_W'(NUM_ENQ)}};
`endif
   end

   // Leading run of valid&ready lanes; everything after the first gap is dropped.
   always_comb begin
      enq_take_c = '0;
      enq_cnt_c  = '0;
      enq_run_c  = 1'b1;
      enq_idx_c  = '0;
      for (int unsigned i = 0; i < NUM_ENQ; i++) begin
         enq_idx_c[i] = enq_ptr_q[LOG_NUM_ENTRIES-1:0] + LOG_NUM_ENTRIES'(i);
         if (enq_run_c && bus.enq_valid_by_lane[i] && enq_ready_c[i]) begin
            enq_take_c[i] = 1'b1;
            enq_cnt_c     = enq_cnt_c + PTR_W'(1);
         end else begin
            enq_run_c = 1'b0;
         end
      end
   end

   // Dequeue lanes present entries[deq_ptr+j] whether or not the lane is valid.
   always_comb begin
      deq_valid_c          = '0;
      deq_idx_c            = '0;
      deq_cnt_c            = '0;
      deq_run_c            = 1'b1;
      bus.deq_data_by_lane = '0;
      for (int unsigned j = 0; j < NUM_DEQ; j++) begin
         deq_valid_c[j]          = (occupancy_c > PTR_W'(j));
         deq_idx_c[j]            = deq_ptr_q[LOG_NUM_ENTRIES-1:0] + LOG_NUM_ENTRIES'(j);
         bus.deq_data_by_lane[j] = entries_q[deq_idx_c[j]];
         if (deq_run_c && deq_valid_c[j] && bus.deq_ready_by_lane[j]) begin
            deq_cnt_c = deq_cnt_c + PTR_W'(1);
         end else begin
            deq_run_c = 1'b0;
         end
      end
   end

   // Flush wins over any same-cycle traffic and rewinds both pointers.
   always_comb begin
      enq_ptr_d = enq_ptr_q + enq_cnt_c;
      deq_ptr_d = deq_ptr_q + deq_cnt_c;
      if (bus.flush) begin
         enq_ptr_d = '0;
         deq_ptr_d = '0;
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         enq_ptr_q <= '0;
         deq_ptr_q <= '0;
      end else begin
         enq_ptr_q <= enq_ptr_d;
         deq_ptr_q <= deq_ptr_d;
      end
   end

   // Entry storage; a flush leaves stale data in place.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         for (int unsigned k = 0; k < NUM_ENTRIES; k++) begin
            entries_q[k] <= '0;
         end
      end else if (!bus.flush) begin
         for (int unsigned i = 0; i < NUM_ENQ; i++) begin
            if (enq_take_c[i]) begin
               entries_q[enq_idx_c[i]] <= bus.enq_data_by_lane[i];
            end
         end
      end
   end

   assign bus.enq_ready_by_lane = enq_ready_c;
   assign bus.deq_valid_by_lane = deq_valid_c;
   assign bus.occupancy         = occupancy_c;
   assign bus.full              = (occupancy_c == PTR_W'(NUM_ENTRIES));
   assign bus.empty             = (occupancy_c == '0);

endmodule

// File: tb/tb_cb_multi.sv
// Bench for cb_multi: directed vector table, wrap/reset sequences, then random traffic against a queue model.
module tb_cb_multi;
   localparam int unsigned DW = 32;
   localparam int unsigned NE = 8;
   localparam int unsigned NQ = 2;
   localparam int unsigned ND = 2;

`ifdef CB_MULTI_PARTIAL_ENQ_EN
   localparam logic [1:0] ER_AT7  = 2'b01;
   localparam int         OCC_TOP = 8;
`else
   localparam logic [1:0] ER_AT7  = 2'b00;
   localparam int         OCC_TOP = 7;
`endif

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   cb_multi_if #(.DATA_WIDTH(DW), .NUM_ENTRIES(NE), .NUM_ENQ(NQ), .NUM_DEQ(ND)) bus ();

   cb_multi #(.DATA_WIDTH(DW), .NUM_ENTRIES(NE), .NUM_ENQ(NQ), .NUM_DEQ(ND)) dut (
      .CLK  (clk),
      .nRST (rst_n),
      .bus  (bus)
   );

   typedef struct {
      logic        fl;
      logic [1:0]  ev;
      logic [31:0] d0;
      logic [31:0] d1;
      logic [1:0]  dr;
      int          occ;
      logic [1:0]  dv;
      logic [31:0] q0;
      logic [31:0] q1;
      logic [1:0]  er;
   } vec_t;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] mq[$];
   logic [31:0] popped[$];
   vec_t        tv[16];

   function automatic vec_t mk(input logic fl, input logic [1:0] ev, input logic [31:0] d0,
                               input logic [31:0] d1, input logic [1:0] dr, input int occ,
                               input logic [1:0] dv, input logic [31:0] q0, input logic [31:0] q1,
                               input logic [1:0] er);
      vec_t v;
      v.fl = fl; v.ev = ev; v.d0 = d0; v.d1 = d1; v.dr = dr;
      v.occ = occ; v.dv = dv; v.q0 = q0; v.q1 = q1; v.er = er;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [1:0] exp_ready(input int occ);
      int         free = NE - occ;
      logic [1:0] r;
`ifdef CB_MULTI_PARTIAL_ENQ_EN
      for (int i = 0; i < NQ; i++) r[i] = (free > i);
`else
      r = (free >= NQ) ? 2'b11 : 2'b00;
`endif
      return r;
   endfunction

   task automatic drive(input logic fl, input logic [1:0] ev, input logic [31:0] d0,
                        input logic [31:0] d1, input logic [1:0] dr);
      bus.flush                = fl;
      bus.enq_valid_by_lane    = ev;
      bus.enq_data_by_lane[0]  = d0;
      bus.enq_data_by_lane[1]  = d1;
      bus.deq_ready_by_lane    = dr;
   endtask

   // Outputs vs the queue model (data only checked on valid lanes).
   task automatic check_model(input string tag);
      int occ = mq.size();
      chk({tag, " occupancy"}, 64'(bus.occupancy), 64'(occ));
      chk({tag, " full"}, 64'(bus.full), 64'(occ == NE));
      chk({tag, " empty"}, 64'(bus.empty), 64'(occ == 0));
      chk({tag, " enq_ready"}, 64'(bus.enq_ready_by_lane), 64'(exp_ready(occ)));
      for (int j = 0; j < ND; j++) begin
         chk($sformatf("%s deq_valid%0d", tag, j), 64'(bus.deq_valid_by_lane[j]), 64'(j < occ));
         if (j < occ) chk($sformatf("%s deq_data%0d", tag, j), 64'(bus.deq_data_by_lane[j]), 64'(mq[j]));
      end
   endtask

   // One clock: record consumed lanes, clock, advance the model, return at negedge.
   task automatic step();
      int         occ = mq.size();
      logic [1:0] er  = exp_ready(occ);
      int         n = 0;
      int         m = 0;
      logic [31:0] nd[2];
      nd[0] = bus.enq_data_by_lane[0];
      nd[1] = bus.enq_data_by_lane[1];
      for (int j = 0; j < ND; j++) begin
         if (j < occ && bus.deq_ready_by_lane[j]) n++;
         else break;
      end
      for (int i = 0; i < NQ; i++) begin
         if (bus.enq_valid_by_lane[i] && er[i]) m++;
         else break;
      end
      if (!bus.flush) for (int k = 0; k < n; k++) popped.push_back(bus.deq_data_by_lane[k]);
      @(posedge clk);
      if (bus.flush) begin
         mq.delete();
      end else begin
         for (int k = 0; k < n; k++) void'(mq.pop_front());
         for (int k = 0; k < m; k++) mq.push_back(nd[k]);
      end
      @(negedge clk);
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, " occupancy"}, 64'(bus.occupancy), 64'd0);
      chk({tag, " empty"}, 64'(bus.empty), 64'd1);
      chk({tag, " full"}, 64'(bus.full), 64'd0);
      chk({tag, " deq_valid"}, 64'(bus.deq_valid_by_lane), 64'd0);
      chk({tag, " deq_data0"}, 64'(bus.deq_data_by_lane[0]), 64'd0);
      chk({tag, " deq_data1"}, 64'(bus.deq_data_by_lane[1]), 64'd0);
      chk({tag, " enq_ready"}, 64'(bus.enq_ready_by_lane), 64'h3);
   endtask

   initial begin
      tv[0]  = mk(0, 2'b11, 32'hA,  32'hB,  2'b00, 0,       2'b00, 0,     0,     2'b11);
      tv[1]  = mk(0, 2'b11, 32'hC,  32'hD,  2'b00, 2,       2'b11, 32'hA, 32'hB, 2'b11);
      tv[2]  = mk(0, 2'b00, 0,      0,      2'b00, 4,       2'b11, 32'hA, 32'hB, 2'b11);
      tv[3]  = mk(0, 2'b00, 0,      0,      2'b11, 4,       2'b11, 32'hA, 32'hB, 2'b11);
      tv[4]  = mk(0, 2'b00, 0,      0,      2'b10, 2,       2'b11, 32'hC, 32'hD, 2'b11);
      tv[5]  = mk(0, 2'b11, 32'hE,  32'hF,  2'b00, 2,       2'b11, 32'hC, 32'hD, 2'b11);
      tv[6]  = mk(0, 2'b11, 32'h10, 32'h11, 2'b00, 4,       2'b11, 32'hC, 32'hD, 2'b11);
      tv[7]  = mk(0, 2'b11, 32'h12, 32'h13, 2'b01, 6,       2'b11, 32'hC, 32'hD, 2'b11);
      tv[8]  = mk(0, 2'b11, 32'h20, 32'h21, 2'b00, 7,       2'b11, 32'hD, 32'hE, ER_AT7);
      tv[9]  = mk(0, 2'b00, 0,      0,      2'b00, OCC_TOP, 2'b11, 32'hD, 32'hE, 2'b00);
      tv[10] = mk(1, 2'b11, 32'h30, 32'h31, 2'b11, OCC_TOP, 2'b11, 32'hD, 32'hE, 2'b00);
      tv[11] = mk(0, 2'b01, 32'h1,  32'h99, 2'b00, 0,       2'b00, 0,     0,     2'b11);
      tv[12] = mk(0, 2'b00, 0,      0,      2'b00, 1,       2'b01, 32'h1, 0,     2'b11);
      tv[13] = mk(0, 2'b00, 0,      0,      2'b01, 1,       2'b01, 32'h1, 0,     2'b11);
      tv[14] = mk(0, 2'b10, 32'h55, 32'h77, 2'b00, 0,       2'b00, 0,     0,     2'b11);
      tv[15] = mk(0, 2'b00, 0,      0,      2'b00, 0,       2'b00, 0,     0,     2'b11);

      rst_n = 1'b0;
      drive(0, 2'b00, 0, 0, 2'b00);
      repeat (2) @(negedge clk);
      check_reset_values("reset");
      rst_n = 1'b1;

      // Directed table
      for (int r = 0; r < 16; r++) begin
         drive(tv[r].fl, tv[r].ev, tv[r].d0, tv[r].d1, tv[r].dr);
         chk($sformatf("row%0d occupancy", r), 64'(bus.occupancy), 64'(tv[r].occ));
         chk($sformatf("row%0d full", r), 64'(bus.full), 64'(tv[r].occ == NE));
         chk($sformatf("row%0d empty", r), 64'(bus.empty), 64'(tv[r].occ == 0));
         chk($sformatf("row%0d deq_valid", r), 64'(bus.deq_valid_by_lane), 64'(tv[r].dv));
         chk($sformatf("row%0d enq_ready", r), 64'(bus.enq_ready_by_lane), 64'(tv[r].er));
         if (tv[r].dv[0]) chk($sformatf("row%0d deq_data0", r), 64'(bus.deq_data_by_lane[0]), 64'(tv[r].q0));
         if (tv[r].dv[1]) chk($sformatf("row%0d deq_data1", r), 64'(bus.deq_data_by_lane[1]), 64'(tv[r].q1));
         step();
      end

      // Wrap across index 7 -> 0 starting from rewound pointers
      drive(1, 2'b00, 0, 0, 2'b00);
      step();
      for (int k = 0; k < 4; k++) begin
         drive(0, 2'b11, 32'(2 * k), 32'(2 * k + 1), 2'b00);
         check_model($sformatf("wrap_fill%0d", k));
         step();
      end
      for (int k = 0; k < 3; k++) begin
         drive(0, 2'b00, 0, 0, 2'b11);
         check_model($sformatf("wrap_drain%0d", k));
         step();
      end
      for (int k = 0; k < 2; k++) begin
         drive(0, 2'b11, 32'(8 + 2 * k), 32'(9 + 2 * k), 2'b00);
         check_model($sformatf("wrap_refill%0d", k));
         step();
      end
      popped.delete();
      for (int k = 0; k < 6 && mq.size() > 0; k++) begin
         drive(0, 2'b00, 0, 0, 2'b11);
         check_model($sformatf("wrap_tail%0d", k));
         step();
      end
      chk("wrap popped_count", 64'(popped.size()), 64'd6);
      for (int k = 0; k < 6 && k < popped.size(); k++)
         chk($sformatf("wrap popped%0d", k), 64'(popped[k]), 64'(6 + k));
      drive(0, 2'b00, 0, 0, 2'b00);
      chk("wrap end occupancy", 64'(bus.occupancy), 64'd0);
      chk("wrap end empty", 64'(bus.empty), 64'd1);

      // Asynchronous reset at occupancy 5 with traffic pending
      drive(0, 2'b11, 32'h111, 32'h222, 2'b00); step();
      drive(0, 2'b11, 32'h333, 32'h444, 2'b00); step();
      drive(0, 2'b01, 32'h555, 32'h666, 2'b00); step();
      check_model("pre_reset");
      drive(0, 2'b11, 32'h777, 32'h888, 2'b00);
      #2 rst_n = 1'b0;
      #1 check_reset_values("midreset");
      mq.delete();
      drive(0, 2'b00, 0, 0, 2'b00);
      @(negedge clk);
      rst_n = 1'b1;

      // Random traffic, alternating fill-biased and drain-biased windows
      for (int k = 0; k < 400; k++) begin
         logic [1:0] dr;
         dr = 2'($urandom);
         if (((k / 40) % 2) == 0 && $urandom_range(0, 3) != 0) dr = 2'b00;
         drive(($urandom_range(0, 24) == 0), 2'($urandom), $urandom, $urandom, dr);
         check_model($sformatf("rand%0d", k));
         step();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/cb_multi.md
Name: cb_multi

Overview:
- Multi-lane circular buffer: up to NUM_ENQ in-order writes and NUM_DEQ in-order reads per cycle.
- Adds enqueue backpressure, occupancy/full/empty status and synchronous flush.
- Sits between wide producer/consumer pipeline stages, e.g. multi-issue instruction/uop queues.

Parameters:
- DATA_WIDTH, 32, bits per entry.
- NUM_ENTRIES, 8, entry count; power of 2, >= max(NUM_ENQ, NUM_DEQ).
- NUM_ENQ, 2, enqueue lanes.
- NUM_DEQ, 2, dequeue lanes.
- LOG_NUM_ENTRIES, $clog2(NUM_ENTRIES), index width (derived).

Ports:
- CLK  input  1  clock.
- nRST  input  1  reset, asynchronous, active-low.
- flush  input  1  synchronous clear of queue contents.
- enq_valid_by_lane  input  NUM_ENQ  per-lane enqueue request.
- enq_data_by_lane  input  NUM_ENQ x DATA_WIDTH  per-lane enqueue data.
- enq_ready_by_lane  output  NUM_ENQ  per-lane enqueue acceptance.
- deq_valid_by_lane  output  NUM_DEQ  lane j holds a valid entry.
- deq_data_by_lane  output  NUM_DEQ x DATA_WIDTH  entry at deq_ptr+j.
- deq_ready_by_lane  input  NUM_DEQ  consumer takes lane j.
- occupancy  output  LOG_NUM_ENTRIES+1  current valid entry count.
- full  output  1  occupancy == NUM_ENTRIES.
- empty  output  1  occupancy == 0.

Behaviour:
- Pointers: enq_ptr and deq_ptr, each LOG_NUM_ENTRIES+1 bits (extra wrap bit).
  - Index = low LOG_NUM_ENTRIES bits; all index arithmetic is mod NUM_ENTRIES.
  - occupancy = enq_ptr - deq_ptr (mod 2^(LOG+1)).
  - free = NUM_ENTRIES - occupancy.
- Reset (async, nRST low):
  - ptrs = 0, all entries = 0.
  - Outputs: occupancy 0, empty 1, full 0, deq_valid_by_lane all 0, deq_data_by_lane all 0, enq_ready_by_lane all 1.
  - Reset mid-operation discards everything immediately (asynchronous).
- Deq outputs (combinational from registered state):
  - deq_valid_by_lane[j] = (occupancy > j).
  - deq_data_by_lane[j] = entries[deq_ptr+j] regardless of valid.
- Deq count = length of the leading run of lanes with valid&ready starting at lane 0.
  - Lanes after the first gap are not consumed, e.g. ready=10 consumes 0.
  - deq_ptr += deq count.
- Enq ready (from registered state only; same-cycle dequeues do not raise it):
  - All lanes equal (free >= NUM_ENQ); all-or-nothing.
  - Exception: partial mode under the macro below.
- Enq count = length of the leading run of lanes with valid&ready starting at lane 0.
  - Lane i writes entries[enq_ptr+k], where k is its position in that run.
  - Lanes after the first gap are dropped.
  - enq_ptr += enq count.
- Simultaneous enq and deq in one cycle: both apply.
  - New occupancy = old + enq count - deq count.
  - Overflow and underflow are impossible by construction.
- Latency: an enqueued entry is visible on deq lanes the cycle after acceptance; no same-cycle bypass.
- Wrap-around: order is preserved across index NUM_ENTRIES-1 -> 0 for every lane.
- flush=1:
  - Next cycle ptrs = 0 and occupancy = 0.
  - Enq and deq activity in the flush cycle is ignored; no pointer movement, no writes.
  - Entry data is not cleared.
  - enq_ready and deq_valid outputs in the flush cycle still reflect pre-flush state.

Optional Feature:
- Macro CB_MULTI_PARTIAL_ENQ_EN.
- Defined: enq_ready_by_lane[i] = (free > i), so a partial group is accepted when fewer than NUM_ENQ slots are free.
- Undefined: all-or-nothing as above; every enq_ready_by_lane bit = (free >= NUM_ENQ).

Test Plan:
- Reset (NUM_ENTRIES=8, NUM_ENQ=2, NUM_DEQ=2) -> occupancy=0, empty=1, full=0, deq_valid=00, deq_data=0/0, enq_ready=11; assert nRST low mid-traffic at occupancy 5 -> same values immediately.
- Enq 0xA,0xB, next cycle 0xC,0xD, deq_ready=00 -> deq lanes show A,B, occupancy 4; then deq_ready=11 -> next cycle lanes show C,D, occupancy 2; deq_ready=10 -> no change.
- Fill to occupancy 7 -> macro off: enq_ready=00; macro on: enq_ready=01, enq valid=11 accepts only lane 0 -> occupancy 8, full=1, enq_ready=00.
- Wrap: enq 8 values 0..7, deq 6, enq 8..11 -> deq sequence continues 6,7,8,9,10,11 across index 7->0, occupancy 0 and empty=1 at end.
- Simultaneous: occupancy 6, enq valid=11 (ready=11), deq_ready=01 -> occupancy 7; enq valid=01 (lane 1 gap) -> only lane 0 written.
- Flush with occupancy 5, enq valid=11 and deq_ready=11 same cycle -> next cycle occupancy=0, empty=1, deq_valid=00, no entries written, then enq 0x1 -> appears on deq lane 0 one cycle later.
